myadder1_axis_pkt_gen: RTL and testbench
========================================

MYADDER1_AXIS_PKT_GEN -- requirements
Module: myadder1_axis_pkt_gen

Interface
REQ-001 Parameter C_DATA_WIDTH SHALL default 32: stream data width in bits.
REQ-002 Parameter C_LEN_WIDTH SHALL default 16: packet-length field width in beats.
REQ-003 clk  input  1  SHALL be the single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  SHALL be reset: synchronous, active-high.
REQ-005 cmd_valid  input  1  SHALL qualify a packet command.
REQ-006 cmd_ready  output  1  SHALL indicate the command is accepted.
REQ-007 cmd_len  input  C_LEN_WIDTH  SHALL give packet length in beats.
REQ-008 cmd_seed  input  C_DATA_WIDTH  SHALL give first-beat data value.
REQ-009 m_axis_tvalid  output  1  SHALL be AXI4-Stream TVALID.
REQ-010 m_axis_tready  input  1  SHALL be AXI4-Stream TREADY.
REQ-011 m_axis_tdata  output  C_DATA_WIDTH  SHALL be AXI4-Stream TDATA.
REQ-012 m_axis_tlast  output  1  SHALL be AXI4-Stream TLAST.
REQ-013 busy  output  1  SHALL be high while a packet is in flight.
REQ-014 done  output  1  SHALL be a one-cycle completion pulse.
REQ-015 beat_count  output  32  SHALL give total beats transferred (see Configuration).

Function
REQ-016 States SHALL be IDLE and SEND only.
REQ-017 IDLE: cmd_ready=1, m_axis_tvalid=0, busy=0; SEND: cmd_ready=0, m_axis_tvalid=1, busy=1.
REQ-018 Command SHALL be accepted on the edge where cmd_valid & cmd_ready; cmd_len/cmd_seed sampled on that edge only.
REQ-019 Accept with cmd_len!=0 SHALL enter SEND next cycle with tdata=cmd_seed, remaining=cmd_len.
REQ-020 Accept with cmd_len==0 SHALL stay IDLE, emit no beats, pulse done the next cycle.
REQ-021 Beat handshake = m_axis_tvalid & m_axis_tready; on it tdata SHALL increment by 1 modulo 2^C_DATA_WIDTH and remaining SHALL decrement by 1.
REQ-022 m_axis_tlast SHALL be 1 exactly when in SEND and remaining==1; 0 otherwise.
REQ-023 While tvalid=1 and tready=0, tdata and tlast SHALL hold stable (no change, no retraction).
REQ-024 Handshake of the tlast beat SHALL return to IDLE next cycle and pulse done=1 for that one cycle.
REQ-025 cmd_ready SHALL be 1 in the done cycle; back-to-back packets SHALL have exactly one idle cycle between last beat and next first beat.
REQ-026 cmd_len = 2^C_LEN_WIDTH-1 SHALL emit that many beats without counter overflow.
REQ-027 Latency: first beat valid 1 cycle after command acceptance; no further bubbles while tready=1.
REQ-028 cmd_valid during SEND SHALL be ignored (not accepted, not queued).

Reset
REQ-029 On rst=1 state SHALL go IDLE; m_axis_tvalid, m_axis_tlast, busy, done = 0; m_axis_tdata = 0; remaining = 0; beat_count = 0.
REQ-030 rst mid-packet SHALL abandon the packet: tvalid=0 the cycle after rst sampled, no done pulse, no tlast.
REQ-031 rst SHALL take priority over every handshake on the same edge.
REQ-032 cmd_ready SHALL be 0 while rst=1 and 1 from the first cycle after rst deasserts.

Configuration
REQ-033 Macro MYADDER1_PKT_GEN_BEAT_CNT_EN SHALL, when defined, enable a 32-bit counter incrementing on every beat handshake, wrapping 0xFFFFFFFF->0, cleared only by rst, driven on beat_count.
REQ-034 Without MYADDER1_PKT_GEN_BEAT_CNT_EN, beat_count SHALL be tied to 0 and no counter register SHALL exist; all other behaviour identical.

Verification
REQ-035 Reset then cmd_len=4, seed=0x10, tready=1 -> tdata 0x10,0x11,0x12,0x13 on 4 consecutive cycles, tlast on 0x13 only, done pulse next cycle.
REQ-036 cmd_len=3, seed=0xFFFFFFFE, tready toggled 1,0,0,1,0,1 -> beats 0xFFFFFFFE,0xFFFFFFFF,0x00000000 with data/tlast held during stalls.
REQ-037 cmd_len=0 -> no tvalid, done high exactly one cycle after acceptance, cmd_ready stays 1.
REQ-038 Two commands len=2 then len=1 with cmd_valid held high -> 3 beats, one idle cycle between packets, two done pulses.
REQ-039 rst asserted after 2nd beat of len=8 packet -> tvalid 0 next cycle, no done, beat_count=0 (macro on), subsequent len=1 packet completes normally.

Source files
------------

// File: rtl/myadder1_axis_pkt_gen.sv
// myadder1_axis_pkt_gen: AXI4-Stream packet generator emitting cmd_len incrementing beats from cmd_seed
//
// Ports:
//   clk, rst          : single clock, synchronous active-high reset
//   cmd_valid/ready   : packet command handshake (ready only while idle and not in reset)
//   cmd_len           : packet length in beats (0 = no beats, done pulse only)
//   cmd_seed          : data value of the first beat
//   m_axis_*          : AXI4-Stream master (tvalid, tready, tdata, tlast)
//   busy              : high while a packet is in flight
//   done              : one-cycle pulse after the last beat (or after a zero-length command)
//   beat_count        : total beats transferred; live only with MYADDER1_PKT_GEN_BEAT_CNT_EN
//
// Build option: define MYADDER1_PKT_GEN_BEAT_CNT_EN to add the 32-bit beat counter;
// otherwise beat_count is tied to zero.
module myadder1_axis_pkt_gen #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [C_LEN_WIDTH-1:0]  cmd_len,
    input  logic [C_DATA_WIDTH-1:0] cmd_seed,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             beat_count
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t                  r_state;
    logic [C_DATA_WIDTH-1:0] r_tdata;
    logic [C_LEN_WIDTH-1:0]  r_rem;
    logic                    r_done;
    logic                    w_beat;
    logic                    w_last;

    assign w_beat        = (r_state == SEND) && m_axis_tready;
    assign w_last        = (r_state == SEND) && (r_rem == C_LEN_WIDTH'(1));
    // Gated by rst so no command can be seen as accepted on a reset edge.
    assign cmd_ready     = (r_state == IDLE) && !rst;
    assign m_axis_tvalid = (r_state == SEND);
    assign busy          = (r_state == SEND);
    assign m_axis_tlast  = w_last;
    assign m_axis_tdata  = r_tdata;
    assign done          = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tdata <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        r_state <= SEND;
                        r_tdata <= cmd_seed;
                        r_rem   <= cmd_len;
                    end else begin
                        r_done  <= 1'b1;
                    end
                end
            end else if (m_axis_tready) begin
                r_tdata <= r_tdata + C_DATA_WIDTH'(1);
                r_rem   <= r_rem - C_LEN_WIDTH'(1);
                if (w_last) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

`ifdef MYADDER1_PKT_GEN_BEAT_CNT_EN
    logic [31:0] r_beat_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_beat_cnt <= '0;
        else if (w_beat)
            r_beat_cnt <= r_beat_cnt + 32'd1;
    end

    assign beat_count = r_beat_cnt;
`else
    logic w_unused;

    assign w_unused   = w_beat;
    assign beat_count = '0;
`endif
endmodule

// File: tb/tb_myadder1_axis_pkt_gen.sv
// tb_myadder1_axis_pkt_gen: queue-model scoreboard bench for myadder1_axis_pkt_gen
module tb_myadder1_axis_pkt_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_len = '0;
    logic [31:0] cmd_seed = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic [31:0] beat_count;

    myadder1_axis_pkt_gen dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_seed(cmd_seed),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int tr_mode = 0;

    logic [31:0] eq_data[$];
    logic        eq_last[$];
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int unsigned m_cnt = 0;

    logic [31:0] obs_data[$];
    logic        obs_last[$];
    int          obs_cyc[$];
    int          done_cyc[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    // Packet-level model: a command becomes a queue of expected beats.
    always @(negedge clk) begin
        cyc++;
        chk("cmd_ready", cmd_ready, !rst && !m_busy);
        chk("tvalid", m_axis_tvalid, m_busy);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("tlast", m_axis_tlast, m_busy ? eq_last[0] : 1'b0);
        if (m_busy) chk("tdata", m_axis_tdata, eq_data[0]);
`ifdef MYADDER1_PKT_GEN_BEAT_CNT_EN
        chk("beat_count", beat_count, m_cnt);
`else
        chk("beat_count", beat_count, 0);
`endif
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            obs_data.push_back(m_axis_tdata);
            obs_last.push_back(m_axis_tlast);
            obs_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
            eq_data.delete();
            eq_last.delete();
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (m_axis_tready) begin
                    void'(eq_data.pop_front());
                    void'(eq_last.pop_front());
                    m_cnt++;
                    if (eq_data.size() == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (cmd_valid) begin
                if (cmd_len == 0) m_done = 1'b1;
                else begin
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        eq_data.push_back(32'(cmd_seed + 32'(i)));
                        eq_last.push_back(i == int'(cmd_len) - 1);
                    end
                    m_busy = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tr_mode == 0) m_axis_tready = 1'b1;
            else if (tr_mode == 1) m_axis_tready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 200) begin
            cycle();
            n++;
        end
        if (n >= 200) fail_now("wait_ready");
        cycle();
    endtask

    task automatic send_cmd(input int len, input logic [31:0] seed);
        cmd_valid = 1'b1;
        cmd_len   = 16'(len);
        cmd_seed  = seed;
        wait_ready();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) fail_now("wait_idle");
        cycle();
    endtask

    initial begin
        int b0, d0, acc;
        logic pat[6];
        repeat (3) cycle();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_cnt", beat_count, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        b0 = obs_data.size(); d0 = done_cyc.size();
        send_cmd(4, 32'h10);
        acc = cyc;
        wait_idle(50);
        chk("p4_beats", obs_data.size(), b0 + 4);
        chk("p4_lat", obs_cyc[b0], acc + 1);
        for (int i = 0; i < 4; i++) begin
            chk("p4_data", obs_data[b0+i], 32'h10 + 32'(i));
            chk("p4_last", obs_last[b0+i], i == 3);
            chk("p4_cyc", obs_cyc[b0+i], acc + 1 + i);
        end
        chk("p4_done_n", done_cyc.size(), d0 + 1);
        chk("p4_done_cyc", done_cyc[d0], acc + 5);

        tr_mode = 2;
        b0 = obs_data.size();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        send_cmd(3, 32'hFFFF_FFFE);
        acc = cyc;
        m_axis_tready = pat[0];
        for (int i = 1; i < 6; i++) begin
            cycle();
            m_axis_tready = pat[i];
        end
        cycle();
        tr_mode = 0;
        wait_idle(50);
        chk("wrap_beats", obs_data.size(), b0 + 3);
        chk("wrap_d0", obs_data[b0], 32'hFFFF_FFFE);
        chk("wrap_d1", obs_data[b0+1], 32'hFFFF_FFFF);
        chk("wrap_d2", obs_data[b0+2], 32'h0000_0000);
        chk("wrap_last", {obs_last[b0], obs_last[b0+1], obs_last[b0+2]}, 3'b001);
        chk("wrap_c1", obs_cyc[b0+1], acc + 4);
        chk("wrap_c2", obs_cyc[b0+2], acc + 6);

        b0 = obs_data.size(); d0 = done_cyc.size();
        send_cmd(0, 32'h5);
        acc = cyc;
        cycle(); cycle();
        chk("len0_beats", obs_data.size(), b0);
        chk("len0_done_n", done_cyc.size(), d0 + 1);
        chk("len0_done_cyc", done_cyc[d0], acc + 1);

        b0 = obs_data.size(); d0 = done_cyc.size();
        cmd_valid = 1'b1; cmd_len = 16'd2; cmd_seed = 32'hA0;
        wait_ready();
        cmd_len = 16'd1; cmd_seed = 32'hB0;
        wait_ready();
        cmd_valid = 1'b0;
        wait_idle(50);
        chk("b2b_beats", obs_data.size(), b0 + 3);
        chk("b2b_data", {obs_data[b0], obs_data[b0+1], obs_data[b0+2]}, {32'hA0, 32'hA1, 32'hB0});
        chk("b2b_gap", obs_cyc[b0+2] - obs_cyc[b0+1], 2);
        chk("b2b_done_n", done_cyc.size(), d0 + 2);

        b0 = obs_data.size(); d0 = done_cyc.size();
        send_cmd(8, 32'h100);
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("abort_tvalid", m_axis_tvalid, 0);
        chk("abort_cnt", beat_count, 0);
        chk("abort_beats", obs_data.size(), b0 + 2);
        cycle();
        chk("abort_no_done", done_cyc.size(), d0);
        send_cmd(1, 32'h55);
        wait_idle(50);
        chk("after_abort_data", obs_data[obs_data.size()-1], 32'h55);
        chk("after_abort_last", obs_last[obs_last.size()-1], 1);
        chk("after_abort_done", done_cyc.size(), d0 + 1);

        b0 = obs_data.size();
        send_cmd(65535, 32'hFFFF_0000);
        wait_idle(70000);
        chk("max_beats", obs_data.size(), b0 + 65535);
        chk("max_last_data", obs_data[obs_data.size()-1], 32'hFFFF_FFFE);
        chk("max_last_flag", obs_last[obs_last.size()-1], 1);
        obs_data.delete(); obs_last.delete(); obs_cyc.delete();

        tr_mode = 1;
        repeat (60) begin
            repeat ($urandom_range(0, 2)) cycle();
            send_cmd($urandom_range(0, 9),
                     ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom);
            if ($urandom_range(0, 2) == 0 && busy) begin
                cmd_valid = 1'b1;
                cmd_len   = 16'($urandom_range(1, 5));
                cmd_seed  = $urandom;
                cycle();
                cmd_valid = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) begin
                cycle();
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            if ($urandom_range(0, 1) == 0) wait_idle(200);
        end
        tr_mode = 0;
        wait_idle(200);
        repeat (3) cycle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
